// File: rtl/fccc_supervisor_pkg.sv
// Shared state encodings, settle latency and counter-width helper for the
// FCCC clock supervisor.
package fccc_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } sup_state_e;

  // Cycles the GCLKINT enable synchroniser needs before GL1 is usable.
  localparam int unsigned SETTLE_LAT = 2;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gl1_gate_arbiter.sv
// GL1 clock-gate control: turns GL1_EN on for any request, waits for the
// gate to settle before acknowledging, and turns it off after an idle delay.
module gl1_gate_arbiter
  import fccc_supervisor_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned GL1_OFF_DELAY = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               active,
  input  logic [NUM_REQ-1:0] REQ,
  output logic               GL1_EN,
  output logic [NUM_REQ-1:0] ACK
);

  localparam int unsigned IDLE_W   = cnt_w(GL1_OFF_DELAY);
  localparam int unsigned SETTLE_W = cnt_w(SETTLE_LAT);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(GL1_OFF_DELAY - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_LAT - 1);

  logic                en_q, en_d;
  logic                settled_q, settled_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

  // Next-state for enable, settle, idle and acknowledge.
  always_comb begin
    en_d      = en_q;
    settled_d = settled_q;
    settle_d  = settle_q;
    idle_d    = idle_q;
    ack_d     = ack_q;
    if (!active) begin
      en_d      = 1'b0;
      settled_d = 1'b0;
      settle_d  = '0;
      idle_d    = '0;
      ack_d     = '0;
    end else begin
      ack_d = REQ & {NUM_REQ{settled_q}};
      if (!en_q) begin
        if (|REQ) begin
          // The enabling edge already counts as the first settle cycle.
          en_d      = 1'b1;
          settled_d = 1'b0;
          settle_d  = SETTLE_W'(1);
          idle_d    = '0;
        end
      end else begin
        if (!settled_q) begin
          if (settle_q >= SETTLE_LAST) settled_d = 1'b1;
          else                         settle_d  = settle_q + SETTLE_W'(1);
        end
        if (|REQ) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          en_d      = 1'b0;
          settled_d = 1'b0;
          settle_d  = '0;
          idle_d    = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
    end
  end

  // Gate-control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      en_q      <= 1'b0;
      settled_q <= 1'b0;
      settle_q  <= '0;
      idle_q    <= '0;
      ack_q     <= '0;
    end else begin
      en_q      <= en_d;
      settled_q <= settled_d;
      settle_q  <= settle_d;
      idle_q    <= idle_d;
      ack_q     <= ack_d;
    end
  end

  assign GL1_EN = en_q;
  assign ACK    = ack_q;

endmodule

// File: rtl/fccc_clock_supervisor.sv
// FCCC power-up supervisor: synchronises and qualifies LOCK, holds the
// system reset, forces a safe state on lock loss and hosts the GL1 gate.
//
// state        | meaning
// WAIT_LOCK    | waiting for synchronised LOCK
// STABILIZE    | counting consecutive LOCK-high cycles
// RUN          | lock qualified; reset hold then released, GL1 gating live
// FAULT        | lock lost from RUN; safe state until CLR_LOST
module fccc_clock_supervisor
  import fccc_supervisor_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned NUM_REQ            = 2,
  parameter int unsigned GL1_OFF_DELAY      = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOCK_IN,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               CLR_LOST,
  output logic               SYS_RESET_N,
  output logic               GL1_EN,
  output logic [NUM_REQ-1:0] ACK,
  output logic               LOCK_LOST,
  output logic [1:0]         STATE
);

  localparam int unsigned STAB_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int unsigned HOLD_W = cnt_w(RST_HOLD_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  logic              lock_meta_q, lock_meta_d;
  logic              lock_s_q, lock_s_d;
  sup_state_e        state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rst_n_q, rst_n_d;
  logic              lost_q, lost_d;
  logic              active;

  // Two-flop LOCK synchroniser.
  always_comb begin
    lock_meta_d = LOCK_IN;
    lock_s_d    = lock_meta_q;
  end

  // FSM next-state, stable/hold counters, reset release and fault flag.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    rst_n_d = rst_n_q;
    lost_d  = lost_q;
    if (CLR_LOST) lost_d = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        stab_d  = '0;
        rst_n_d = 1'b0;
        if (lock_s_q) state_d = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        rst_n_d = 1'b0;
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
          hold_d  = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          // Lock loss wins over CLR_LOST in the same cycle.
          state_d = ST_FAULT;
          rst_n_d = 1'b0;
          lost_d  = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          rst_n_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_FAULT: begin
        rst_n_d = 1'b0;
        if (CLR_LOST) begin
          state_d = ST_WAIT_LOCK;
          lost_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        rst_n_d = 1'b0;
      end
    endcase
  end

  // Supervisor registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      stab_q      <= '0;
      hold_q      <= '0;
      rst_n_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      state_q     <= state_d;
      stab_q      <= stab_d;
      hold_q      <= hold_d;
      rst_n_q     <= rst_n_d;
      lost_q      <= lost_d;
    end
  end

  // lock_s is folded in so the gate shuts on the same edge the FSM enters FAULT.
  assign active = (state_q == ST_RUN) && rst_n_q && lock_s_q;

  gl1_gate_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .GL1_OFF_DELAY (GL1_OFF_DELAY)
  ) u_gl1_gate_arbiter (
    .CLK    (CLK),
    .RESET  (RESET),
    .active (active),
    .REQ    (REQ),
    .GL1_EN (GL1_EN),
    .ACK    (ACK)
  );

  assign SYS_RESET_N = rst_n_q;
  assign LOCK_LOST   = lost_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_fccc_clock_supervisor.sv
// Directed bench for fccc_clock_supervisor with small timing parameters.
module tb_fccc_clock_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       lock_in;
  logic [1:0] req;
  logic       clr_lost;
  logic       sys_reset_n;
  logic       gl1_en;
  logic [1:0] ack;
  logic       lock_lost;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fccc_clock_supervisor #(
    .LOCK_STABLE_CYCLES (8),
    .RST_HOLD_CYCLES    (4),
    .NUM_REQ            (2),
    .GL1_OFF_DELAY      (3)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .LOCK_IN     (lock_in),
    .REQ         (req),
    .CLR_LOST    (clr_lost),
    .SYS_RESET_N (sys_reset_n),
    .GL1_EN      (gl1_en),
    .ACK         (ack),
    .LOCK_LOST   (lock_lost),
    .STATE       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] r, input logic exp_en, input logic [1:0] exp_ack,
                      input string tag);
    req = r;
    tick();
    check({tag, " gl1_en"}, gl1_en, exp_en);
    check({tag, " ack"}, ack, exp_ack);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, state, 0);
    check({tag, " sys_reset_n"}, sys_reset_n, 0);
    check({tag, " gl1_en"}, gl1_en, 0);
    check({tag, " ack"}, ack, 0);
    check({tag, " lock_lost"}, lock_lost, 0);
  endtask

  task automatic apply_reset(input string tag);
    reset   = 1'b1;
    lock_in = 1'b0;
    req     = 2'b00;
    repeat (2) tick();
    check_reset_values(tag);
    reset = 1'b0;
  endtask

  // Cycle c = c-th edge after LOCK_IN first goes high. With glitch, LOCK_IN
  // is low for edges 6..8: FSM sees it at 8..10, restabilises from edge 11.
  task automatic powerup(input bit glitch);
    int last;
    int es;
    logic er;
    last = glitch ? 23 : 15;
    for (int c = 1; c <= last; c++) begin
      lock_in = !(glitch && c >= 6 && c <= 8);
      tick();
      if (!glitch) begin
        es = (c < 3) ? 0 : (c < 11) ? 1 : 2;
        er = (c >= 15);
      end else begin
        es = (c < 3) ? 0 : (c < 8) ? 1 : (c < 11) ? 0 : (c < 19) ? 1 : 2;
        er = (c >= 23);
      end
      check($sformatf("pwr%0d c%0d state", glitch, c), state, es);
      check($sformatf("pwr%0d c%0d sys_reset_n", glitch, c), sys_reset_n, er);
      check($sformatf("pwr%0d c%0d gl1_en", glitch, c), gl1_en, 0);
      check($sformatf("pwr%0d c%0d ack", glitch, c), ack, 0);
    end
  endtask

  initial begin
    clr_lost = 1'b0;
    apply_reset("reset");
    powerup(1'b0);
    apply_reset("reset_run");
    powerup(1'b1);

    // Handshake.
    step(2'b01, 1, 2'b00, "hs+1");
    step(2'b01, 1, 2'b00, "hs+2");
    step(2'b01, 1, 2'b01, "hs+3");
    step(2'b01, 1, 2'b01, "hs+4");
    step(2'b11, 1, 2'b11, "hs_both");
    step(2'b00, 1, 2'b00, "off+1");
    step(2'b00, 1, 2'b00, "off+2");
    step(2'b00, 0, 2'b00, "off+3");
    // Request right after the gate drops: full enable sequence again.
    step(2'b10, 1, 2'b00, "re+1");
    step(2'b10, 1, 2'b00, "re+2");
    step(2'b10, 1, 2'b10, "re+3");
    // Off-delay cancel after two idle cycles: no re-settle.
    step(2'b00, 1, 2'b00, "cancel_idle1");
    step(2'b00, 1, 2'b00, "cancel_idle2");
    step(2'b10, 1, 2'b10, "cancel_req");
    step(2'b10, 1, 2'b10, "cancel_hold");
    step(2'b11, 1, 2'b11, "pre_loss");

    // Lock loss in RUN with ACK=11.
    lock_in = 1'b0;
    step(2'b11, 1, 2'b11, "loss+1");
    check("loss+1 state", state, 2);
    step(2'b11, 1, 2'b11, "loss+2");
    check("loss+2 state", state, 2);
    step(2'b11, 0, 2'b00, "loss+3");
    check("loss+3 state", state, 3);
    check("loss+3 sys_reset_n", sys_reset_n, 0);
    check("loss+3 lock_lost", lock_lost, 1);
    lock_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 0, 2'b00, "fault_hold");
      check("fault_hold state", state, 3);
      check("fault_hold lock_lost", lock_lost, 1);
    end
    clr_lost = 1'b1;
    step(2'b11, 0, 2'b00, "clr");
    check("clr state", state, 0);
    check("clr lock_lost", lock_lost, 0);
    clr_lost = 1'b0;

    // Relock with REQ held; lock_s is already high.
    step(2'b11, 0, 2'b00, "relock_stab");
    check("relock_stab state", state, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("relock_cnt state", state, 1);
    end
    tick();
    check("relock_run state", state, 2);
    check("relock_run sys_reset_n", sys_reset_n, 0);
    repeat (3) tick();
    check("relock_hold sys_reset_n", sys_reset_n, 0);
    step(2'b11, 0, 2'b00, "relock_rel");
    check("relock_rel sys_reset_n", sys_reset_n, 1);
    step(2'b11, 1, 2'b00, "relock_en");

    // RESET mid-run with GL1_EN=1.
    reset = 1'b1;
    tick();
    check_reset_values("reset_gl1");
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
